// File: rtl/ro_freq_meter.sv
// ro_freq_meter
//   Multi-channel ring-oscillator frequency meter. Each oscillator tap is
//   synchronised into clk. One selected channel has its rising edges counted
//   over a programmable gate of clk cycles. The result is then streamed out
//   least-significant byte first over a valid/ready byte port.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   ro_in       in   [N_CH-1:0] oscillator taps, asynchronous to clk
//   start       in   begin a measurement (only honoured in IDLE)
//   ch_sel      in   [SEL_W-1:0] channel index, latched when start is accepted
//   gate_len    in   [GATE_W-1:0] gate length in clk cycles, 0 = 2^GATE_W
//   busy        out  high from accepted start until done
//   done        out  one-cycle pulse after the last byte handshake
//   overflow    out  edge counter saturated, sticky until next accepted start
//   count       out  [CNT_W-1:0] last result, held until next accepted start
//   byte_out    out  [7:0] readout data
//   byte_valid  out  readout valid
//   byte_ready  in   readout ready from consumer
//
// State table
//   IDLE | waiting for start, result registers hold last measurement
//   ARM  | load gate down-counter with the latched gate length
//   GATE | count rising edges of the selected channel for G cycles
//   OUT  | present the result byte by byte on the valid/ready port

module ro_freq_meter #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 12,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   ro_in,
    input  logic              start,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready
);

    localparam int NB    = (CNT_W + 7) / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int PAD_W = NB * 8;

    localparam logic [GATE_W:0]  GATE_LAST = {{GATE_W{1'b0}}, 1'b1};
    localparam logic [GATE_W:0]  GATE_FULL = {1'b1, {GATE_W{1'b0}}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state;
    logic [N_CH-1:0]   s1, s2, s3;
    logic [N_CH-1:0]   rise;
    logic              rise_sel;
    logic [SEL_W-1:0]  ch_q;
    logic [GATE_W-1:0] glen_q;
    logic [GATE_W:0]   gate_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              cnt_sat;
    logic [IDX_W-1:0]  byte_idx;

    // Result byte k of the zero-padded count.
    function automatic logic [7:0] byte_sel(input logic [CNT_W-1:0] v,
                                            input logic [IDX_W-1:0] k);
        logic [PAD_W-1:0] p;
        p = PAD_W'(v);
        return p[8*k +: 8];
    endfunction

    // Two-flop synchroniser plus history flop on every channel, always running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= ro_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign cnt_sat = &cnt;

    always_comb begin
        rise_sel = 1'b0;
        if (int'(ch_q) < N_CH) begin
            rise_sel = rise[ch_q];
        end
    end

    // Saturating increment; the counter holds at all-ones.
    always_comb begin
        cnt_next = cnt;
        if (rise_sel && !cnt_sat) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ch_q       <= '0;
            glen_q     <= '0;
            gate_cnt   <= '0;
            cnt        <= '0;
            byte_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            count      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high in the cycle the FSM lands in IDLE;
                    // a start seen then is dropped.
                    if (start && !done) begin
                        ch_q     <= ch_sel;
                        glen_q   <= gate_len;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    gate_cnt <= (glen_q == '0) ? GATE_FULL : {1'b0, glen_q};
                    state    <= GATE;
                end
                GATE: begin
                    cnt      <= cnt_next;
                    gate_cnt <= gate_cnt - 1'b1;
                    if (rise_sel && cnt_sat) begin
                        overflow <= 1'b1;
                    end
                    if (gate_cnt == GATE_LAST) begin
                        count    <= cnt_next;
                        byte_idx <= '0;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (!byte_valid) begin
                        byte_valid <= 1'b1;
                        byte_out   <= byte_sel(count, '0);
                    end else if (byte_ready) begin
                        if (byte_idx == IDX_LAST) begin
                            byte_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            byte_out <= byte_sel(count, byte_idx + 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter
//   Testbench for ro_freq_meter. Oscillator taps are periodic square waves
//   defined per channel (period/phase in clk cycles). Expected counts come from
//   the vector table or from a reference model that counts 0->1 transitions of
//   the sampled tap waveform inside the gate window.

module tb_ro_freq_meter;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_CH-1:0]  ro_in = '0;
    logic             start = 1'b0;
    logic [SEL_W-1:0] ch_sel = '0;
    logic [11:0]      gate_len = '0;
    logic             busy, done, overflow, byte_valid;
    logic [15:0]      count;
    logic [7:0]       byte_out;
    logic             byte_ready = 1'b0;

    logic             start10 = 1'b0;
    logic             busy10, done10, ovf10, valid10;
    logic [9:0]       count10;
    logic [7:0]       byte10;
    logic             ready10 = 1'b0;

    int edge_n = 0;
    int per[N_CH];
    int phase[N_CH];
    int n_checks = 0;
    int n_fail = 0;

    ro_freq_meter #(.N_CH(4), .CNT_W(16), .GATE_W(12)) dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .ch_sel(ch_sel),
        .gate_len(gate_len), .busy(busy), .done(done), .overflow(overflow),
        .count(count), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready)
    );

    ro_freq_meter #(.N_CH(4), .CNT_W(10), .GATE_W(12)) dut10 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start10), .ch_sel(ch_sel),
        .gate_len(gate_len), .busy(busy10), .done(done10), .overflow(ovf10),
        .count(count10), .byte_out(byte10), .byte_valid(valid10),
        .byte_ready(ready10)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Value of channel c as seen by the clk edge numbered k.
    function automatic bit ro_at(input int c, input int k);
        if (per[c] == 0) return 1'b0;
        return ((k + phase[c]) % per[c]) >= (per[c] / 2);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) ro_in[i] = ro_at(i, edge_n + 1);
    end

    // A rise counted at edge e is a 0->1 step between the tap samples taken
    // three and two edges earlier; the gate covers edges t+2 .. t+1+g.
    function automatic int model_rises(input int c, input int t, input int g);
        int n;
        n = 0;
        for (int e = t + 2; e <= t + 1 + g; e++)
            if (ro_at(c, e - 2) && !ro_at(c, e - 3)) n++;
        return n;
    endfunction

    function automatic int exp_byte(input int v, input int i);
        return (v >> (8 * i)) & 255;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_chan(input int c, input int p);
        per[c]   = p;
        phase[c] = (p > 0) ? int'($urandom_range(0, p - 1)) : 0;
    endtask

    // One measurement on the 16-bit instance. exp_in < 0 selects the model.
    // mode: 0 ready held high, 1 random ready, 2 five-cycle stall per byte.
    // Returns at the sample point where done is first seen high.
    task automatic run_one(input string name, input int ch, input int gl,
                           input int exp_in, input int ovf_in, input int mode,
                           input bit disturb);
        int t, g, n, exp_c, exp_o, first_v, done_e, stall, last_hs;
        int hs_e[$];
        logic [7:0] got[$];
        bit hs, seen_done;
        logic [7:0] b;
        g = (gl == 0) ? 4096 : gl;
        ch_sel   = SEL_W'(ch);
        gate_len = 12'(gl);
        start    = 1'b1;
        @(posedge clk); #1;
        t = edge_n;
        start = 1'b0;
        check({name, "_busy_on_start"}, busy, 1);
        check({name, "_count_cleared"}, count, 0);
        if (exp_in < 0) begin
            n = model_rises(ch, t, g);
            exp_c = (n > 65535) ? 65535 : n;
            exp_o = (n > 65535) ? 1 : 0;
        end else begin
            exp_c = exp_in;
            exp_o = ovf_in;
        end
        first_v = -1; done_e = -1; stall = 0; seen_done = 1'b0;
        for (int k = 0; k < g + 200 && !seen_done; k++) begin
            if (disturb) begin
                if (k == 3) begin
                    start  = 1'b1;
                    ch_sel = SEL_W'(ch ^ 1);
                end else begin
                    start = 1'b0;
                end
            end
            case (mode)
                0: byte_ready = 1'b1;
                1: byte_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (byte_valid && stall < 5) begin
                        byte_ready = 1'b0;
                        stall++;
                        check({name, "_byte_held"}, byte_out, exp_byte(exp_c, got.size()));
                    end else begin
                        byte_ready = 1'b1;
                    end
                end
            endcase
            hs = byte_valid && byte_ready;
            b  = byte_out;
            @(posedge clk); #1;
            if (hs) begin
                got.push_back(b);
                hs_e.push_back(edge_n);
                stall = 0;
            end
            if (byte_valid && first_v < 0) first_v = edge_n;
            if (done) begin
                seen_done = 1'b1;
                done_e = edge_n;
            end
        end
        byte_ready = 1'b0;
        start = 1'b0;
        last_hs = (hs_e.size() > 0) ? hs_e[hs_e.size() - 1] : -1;
        check({name, "_done_seen"}, seen_done, 1);
        check({name, "_count"}, count, exp_c);
        check({name, "_overflow"}, overflow, exp_o);
        check({name, "_nbytes"}, got.size(), 2);
        for (int i = 0; i < got.size() && i < 2; i++)
            check({name, "_byte"}, got[i], exp_byte(exp_c, i));
        check({name, "_first_valid_edge"}, first_v, t + 2 + g);
        check({name, "_done_after_last_hs"}, done_e, last_hs);
        if (mode == 0) check({name, "_done_latency"}, done_e, t + 2 + g + 2);
        check({name, "_busy_cleared"}, busy, 0);
    endtask

    // Called at the done sample point.
    task automatic after_done(input string name, input bit start_on_done);
        bit seen;
        if (!start_on_done) begin
            @(posedge clk); #1;
            check({name, "_done_single"}, done, 0);
        end else begin
            ch_sel = 2'd1; gate_len = 12'd8; start = 1'b1;
            @(posedge clk); #1;
            check({name, "_start_on_done_ignored"}, busy, 0);
            @(posedge clk); #1;
            start = 1'b0;
            check({name, "_start_after_done_taken"}, busy, 1);
            byte_ready = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(posedge clk); #1;
                if (done) seen = 1'b1;
            end
            byte_ready = 1'b0;
            check({name, "_second_run_done"}, seen, 1);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int ch; int p; int gl; int exp_cnt; int exp_ovf; int mode;
    } vec_t;

    initial begin : main
        vec_t vecs[$];
        int t, n, ecnt;
        bit seen;
        logic [7:0] got10[$];

        vecs.push_back('{1,  4,  100,  25, 0, 0});
        vecs.push_back('{2,  8,   64,   8, 0, 0});
        vecs.push_back('{0, 10,   50,   5, 0, 0});
        vecs.push_back('{3,  6,  120,  20, 0, 0});
        vecs.push_back('{1, 16,    0, 256, 0, 0});
        vecs.push_back('{0,  4,    4,   1, 0, 0});
        vecs.push_back('{3,  2,    2,   1, 0, 0});
        vecs.push_back('{2,  8, 4000, 500, 0, 1});
        vecs.push_back('{0,  0,   30,   0, 0, 0});
        vecs.push_back('{1,  4,  100,  25, 0, 2});

        for (int i = 0; i < N_CH; i++) set_chan(i, 6 + 2 * i);

        // Reset state
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", count, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst10_count", count10, 0);
        check("rst10_valid", valid10, 0);
        rst = 1'b0;
        idle(4);

        // Table vectors; other channels keep toggling during each run.
        foreach (vecs[i]) begin
            set_chan(vecs[i].ch, vecs[i].p);
            idle(4);
            run_one($sformatf("vec%0d", i), vecs[i].ch, vecs[i].gl,
                    vecs[i].exp_cnt, vecs[i].exp_ovf, vecs[i].mode, 1'b0);
            after_done($sformatf("vec%0d", i), 1'b0);
        end

        // Start pulse and channel change during GATE are ignored; start on the
        // done cycle is dropped and accepted one cycle later.
        set_chan(1, 4);
        set_chan(0, 6);
        idle(4);
        run_one("ignore", 1, 100, 25, 0, 0, 1'b1);
        after_done("ignore", 1'b1);

        // Randomised runs against the model.
        for (int r = 0; r < 25; r++) begin
            int c;
            c = int'($urandom_range(0, N_CH - 1));
            for (int i = 0; i < N_CH; i++) set_chan(i, 2 * int'($urandom_range(2, 10)));
            idle(4);
            run_one($sformatf("rand%0d", r), c, int'($urandom_range(1, 300)),
                    -1, 0, int'($urandom_range(0, 1)), 1'b0);
            after_done($sformatf("rand%0d", r), 1'b0);
        end

        // Saturation on the 10-bit instance.
        set_chan(0, 2);
        phase[0] = 0;
        idle(4);
        ch_sel = 2'd0; gate_len = 12'd0; start10 = 1'b1; ready10 = 1'b1;
        @(posedge clk); #1;
        t = edge_n;
        start10 = 1'b0;
        n = model_rises(0, t, 4096);
        ecnt = (n > 1023) ? 1023 : n;
        seen = 1'b0;
        for (int k = 0; k < 4400 && !seen; k++) begin
            bit hs;
            logic [7:0] b;
            hs = valid10 && ready10;
            b  = byte10;
            @(posedge clk); #1;
            if (hs) got10.push_back(b);
            if (done10) seen = 1'b1;
        end
        ready10 = 1'b0;
        check("sat_done_seen", seen, 1);
        check("sat_count", count10, 1023);
        check("sat_count_model", count10, ecnt);
        check("sat_overflow", ovf10, 1);
        check("sat_nbytes", got10.size(), 2);
        for (int i = 0; i < got10.size() && i < 2; i++)
            check("sat_byte", got10[i], (i == 0) ? 8'hFF : 8'h03);
        check("sat_main_idle", busy, 0);

        // Abort mid-GATE.
        set_chan(2, 8);
        idle(4);
        ch_sel = 2'd2; gate_len = 12'd64; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(20);
        check("abort_gate_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_gate_busy", busy, 0);
        check("abort_gate_count", count, 0);
        check("abort_gate_valid", byte_valid, 0);
        check("abort_gate_done", done, 0);
        check("abort_gate_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        run_one("abort_rerun", 2, 64, 8, 0, 0, 1'b0);
        after_done("abort_rerun", 1'b0);

        // Abort mid-OUT with the first byte pending.
        set_chan(1, 4);
        idle(4);
        ch_sel = 2'd1; gate_len = 12'd100; start = 1'b1; byte_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            if (byte_valid) seen = 1'b1;
        end
        check("abort_out_valid_before", seen, 1);
        check("abort_out_count_before", count, 25);
        idle(2);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", byte_valid, 0);
        check("abort_out_count", count, 0);
        check("abort_out_byte", byte_out, 0);
        check("abort_out_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
